// File: rtl/pv_rts_pkg.sv
// Shared types and constants for the PV real-time solver blocks.
package pv_rts_pkg;
  localparam int SINGLE  = 32;
  localparam int IPH_LAT = 19;

  localparam logic [SINGLE-1:0] FP_1000 = 32'h447A_0000;
  localparam logic [SINGLE-1:0] FP_25   = 32'h41C8_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/iph_result_buf.sv
// Result buffer: simple dual-port RAM, one write port, one registered read port.
module iph_result_buf
  import pv_rts_pkg::*;
#(
  parameter int N_CELL = 8,
  parameter int IDX_W  = $clog2(N_CELL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [SINGLE-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [SINGLE-1:0] o_rd_data
);
  logic [SINGLE-1:0] r_mem [N_CELL];
  logic [SINGLE-1:0] r_rd_data;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_data <= '0;
    else      r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/iph_array_scheduler.sv
// Time-multiplexes one pipelined Iph stage across N_CELL cells per step.
// Optional watchdog on missing results: define IPH_WATCHDOG_EN.
module iph_array_scheduler
  import pv_rts_pkg::*;
#(
  parameter int N_CELL  = 8,
  parameter int IPH_LAT = pv_rts_pkg::IPH_LAT,
  parameter int IDX_W   = $clog2(N_CELL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_start,
  input  logic              cfg_wr_en,
  input  logic              cfg_sel,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [SINGLE-1:0] cfg_wdata,
  output logic              cfg_ready,
  output logic              iph_sta,
  output logic [SINGLE-1:0] iph_S,
  output logic [SINGLE-1:0] iph_T,
  input  logic              iph_done,
  input  logic [SINGLE-1:0] iph_result,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [SINGLE-1:0] rd_data,
  output logic              busy,
  output logic              step_done,
  output logic              err
);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CELL - 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_CELL);

  logic [SINGLE-1:0] r_s_tab [N_CELL];
  logic [SINGLE-1:0] r_t_tab [N_CELL];

  state_t            r_state;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_capture_cnt;
  logic              r_sta;
  logic [SINGLE-1:0] r_S;
  logic [SINGLE-1:0] r_T;
  logic              r_step_done;
  logic              r_err;

  logic              w_busy;
  logic              w_wr_ok;
  logic              w_start_ok;
  logic              w_cap;
  logic              w_err_evt;
  logic [CNT_W-1:0]  w_cap_cnt_next;
  logic [IDX_W-1:0]  w_issue_idx;
  logic [SINGLE-1:0] w_s0;
  logic [SINGLE-1:0] w_t0;

  assign w_busy         = (r_state != IDLE);
  assign w_wr_ok        = cfg_wr_en && !w_busy;
  assign w_start_ok     = step_start && !w_busy;
  assign w_cap          = iph_done && (r_state == ISSUE || r_state == DRAIN) && (r_capture_cnt < N_CNT);
  assign w_cap_cnt_next = r_capture_cnt + CNT_W'(w_cap);
  assign w_err_evt      = (cfg_wr_en && w_busy) || (step_start && w_busy) || (iph_done && !w_cap);
  assign w_issue_idx    = r_issue_cnt[IDX_W-1:0];

  // Cell 0 is issued on the start edge, so a same-cycle write to it is forwarded.
  assign w_s0 = (w_wr_ok && !cfg_sel && cfg_addr == '0) ? cfg_wdata : r_s_tab[0];
  assign w_t0 = (w_wr_ok &&  cfg_sel && cfg_addr == '0) ? cfg_wdata : r_t_tab[0];

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      if (cfg_sel) r_t_tab[cfg_addr] <= cfg_wdata;
      else         r_s_tab[cfg_addr] <= cfg_wdata;
    end
  end

`ifdef IPH_WATCHDOG_EN
  localparam int WD_W = $clog2(IPH_LAT + N_CELL + 8) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(IPH_LAT + N_CELL + 4);
  logic [WD_W-1:0] r_wd_cnt;

  // r_wd_cnt equals the cycle number within the pass (first issue = 1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    r_wd_cnt <= '0;
    else if (w_start_ok)                         r_wd_cnt <= WD_W'(1);
    else if (r_state == ISSUE || r_state == DRAIN) r_wd_cnt <= r_wd_cnt + WD_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_issue_cnt   <= '0;
      r_capture_cnt <= '0;
      r_sta         <= 1'b0;
      r_S           <= '0;
      r_T           <= '0;
      r_step_done   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err       <= (w_start_ok ? 1'b0 : r_err) | w_err_evt;
      r_step_done <= 1'b0;
      if (w_cap) r_capture_cnt <= w_cap_cnt_next;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state       <= ISSUE;
            r_sta         <= 1'b1;
            r_S           <= w_s0;
            r_T           <= w_t0;
            r_issue_cnt   <= CNT_W'(1);
            r_capture_cnt <= '0;
          end
        end
        ISSUE: begin
          r_sta       <= 1'b1;
          r_S         <= r_s_tab[w_issue_idx];
          r_T         <= r_t_tab[w_issue_idx];
          r_issue_cnt <= r_issue_cnt + CNT_W'(1);
          if (r_issue_cnt == LAST_IDX) r_state <= DRAIN;
        end
        DRAIN: begin
          r_sta <= 1'b0;
          if (w_cap_cnt_next == N_CNT) begin
            r_state     <= DONE;
            r_step_done <= 1'b1;
          end
`ifdef IPH_WATCHDOG_EN
          else if (r_wd_cnt == WD_LIMIT) begin
            r_state     <= DONE;
            r_step_done <= 1'b1;
            r_err       <= 1'b1;
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  iph_result_buf #(
    .N_CELL (N_CELL),
    .IDX_W  (IDX_W)
  ) u_result_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_cap),
    .i_wr_addr (r_capture_cnt[IDX_W-1:0]),
    .i_wr_data (iph_result),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign cfg_ready = !w_busy;
  assign busy      = w_busy;
  assign iph_sta   = r_sta;
  assign iph_S     = r_S;
  assign iph_T     = r_T;
  assign step_done = r_step_done;
  assign err       = r_err;
endmodule
